tcp_rx_payload_buf_ctrl: RTL

Parametrised receive-side payload staging controller for the TCP rx pipe. Accepts a parsed header carrying the payload length, then:
- obtains a buffer slab from the allocator;
- streams payload beats into the payload buffer, generating addresses itself;
- hands the header plus payload location downstream.
New relative to the fixed-width controller: configurable beat width, internal wrapping store-address generation, per-beat byte count and last flag, and an optional drop mode that discards payload when no slab is available instead of stalling.

---
 rtl/tcp_rx_buf_pkg.sv | 17 +
 rtl/tcp_rx_payload_buf_datapath.sv | 76 +++++++
 rtl/tcp_rx_payload_buf_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/tcp_rx_buf_pkg.sv
// Shared types for the TCP rx payload staging controller: FSM states and
// the per-beat byte-count helper used by the datapath.
package tcp_rx_buf_pkg;

  typedef enum logic [1:0] {
    ST_READY     = 2'd0,
    ST_DATA_COPY = 2'd1,
    ST_DATA_DROP = 2'd2,
    ST_OUTPUT    = 2'd3
  } state_t;

  // Valid bytes in the current beat: the remainder on the final beat, else a full beat.
  function automatic logic [31:0] beat_bytes(input logic [31:0] rem, input logic [31:0] bytes);
    return (rem <= bytes) ? rem : bytes;
  endfunction

endpackage

// File: rtl/tcp_rx_payload_buf_datapath.sv
// Remaining-byte counter, wrapping store-address counter and latched header
// metadata, driven by strobes from the controller FSM.
module tcp_rx_payload_buf_datapath
  import tcp_rx_buf_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_load_hdr,
  input  logic                           i_load_base,
  input  logic                           i_incr_addr,
  input  logic                           i_dec_rem,
  input  logic                           i_set_drop,
  input  logic [LEN_W-1:0]               i_len,
  input  logic [ADDR_W-1:0]              i_base,
  output logic [ADDR_W-1:0]              o_addr,
  output logic [ADDR_W-1:0]              o_dst_addr,
  output logic [LEN_W-1:0]               o_len,
  output logic                           o_dropped,
  output logic                           o_rem_last,
  output logic [$clog2(DATA_W/8):0]      o_beat_bytes
);

  localparam int BYTES = DATA_W / 8;
  localparam int SB_W  = $clog2(BYTES) + 1;
  localparam logic [LEN_W-1:0] C_BYTES = LEN_W'(BYTES);

  logic [LEN_W-1:0]  r_rem;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_dst_addr;
  logic              r_dropped;
  logic              w_rem_last;

  assign w_rem_last = (r_rem <= C_BYTES);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem      <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_dst_addr <= '0;
      r_dropped  <= 1'b0;
    end else begin
      if (i_load_hdr) begin
        r_len     <= i_len;
        r_rem     <= i_len;
        r_dropped <= i_set_drop;
      end else if ((i_incr_addr || i_dec_rem) && !w_rem_last) begin
        // The final beat leaves rem untouched so the counter never wraps below zero.
        r_rem <= r_rem - C_BYTES;
      end

      if (i_load_base) begin
        r_addr     <= i_base;
        r_dst_addr <= i_base;
      end else if (i_load_hdr) begin
        r_addr     <= '0;
        r_dst_addr <= '0;
      end else if (i_incr_addr) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign o_addr       = r_addr;
  assign o_dst_addr   = r_dst_addr;
  assign o_len        = r_len;
  assign o_dropped    = r_dropped;
  assign o_rem_last   = w_rem_last;
  assign o_beat_bytes = SB_W'(beat_bytes(32'(r_rem), 32'(BYTES)));

endmodule

// File: rtl/tcp_rx_payload_buf_ctrl.sv
// Receive payload staging controller: takes a header, claims a buffer slab,
// streams payload beats into the buffer and forwards header plus location.
module tcp_rx_payload_buf_ctrl
  import tcp_rx_buf_pkg::*;
#(
  parameter int DATA_W       = 512,
  parameter int LEN_W        = 16,
  parameter int ADDR_W       = 8,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      src_hdr_val,
  output logic                      hdr_src_rdy,
  input  logic [LEN_W-1:0]          src_payload_len,
  input  logic                      src_data_val,
  output logic                      data_src_rdy,
  input  logic [DATA_W-1:0]         src_data,
  input  logic                      alloc_avail,
  input  logic [ADDR_W-1:0]         alloc_base_addr,
  output logic                      alloc_consume_val,
  output logic                      store_val,
  input  logic                      store_rdy,
  output logic [ADDR_W-1:0]         store_addr,
  output logic [DATA_W-1:0]         store_data,
  output logic [$clog2(DATA_W/8):0] store_bytes,
  output logic                      store_last,
  output logic                      dst_hdr_val,
  input  logic                      dst_rdy,
  output logic [ADDR_W-1:0]         dst_payload_addr,
  output logic [LEN_W-1:0]          dst_payload_len,
  output logic                      dst_dropped
);

  state_t                      r_state;
  logic                        w_in_ready;
  logic                        w_in_copy;
  logic                        w_in_drop;
  logic                        w_len_zero;
  logic                        w_hdr_acc;
  logic                        w_take_slab;
  logic                        w_set_drop;
  logic                        w_copy_hs;
  logic                        w_drop_hs;
  logic                        w_rem_last;
  logic [ADDR_W-1:0]           w_addr;
  logic [$clog2(DATA_W/8):0]   w_beat_bytes;

  assign w_in_ready  = (r_state == ST_READY);
  assign w_in_copy   = (r_state == ST_DATA_COPY);
  assign w_in_drop   = (r_state == ST_DATA_DROP);
  assign w_len_zero  = (src_payload_len == '0);
  assign w_hdr_acc   = w_in_ready && src_hdr_val && (w_len_zero || alloc_avail || DROP_ON_FULL);
  assign w_take_slab = w_in_ready && src_hdr_val && !w_len_zero && alloc_avail;
  assign w_set_drop  = !w_len_zero && !alloc_avail;
  assign w_copy_hs   = w_in_copy && src_data_val && store_rdy;
  assign w_drop_hs   = w_in_drop && src_data_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_READY;
    end else begin
      case (r_state)
        ST_READY: begin
          if (w_hdr_acc) begin
            if (w_len_zero)       r_state <= ST_OUTPUT;
            else if (alloc_avail) r_state <= ST_DATA_COPY;
            else                  r_state <= ST_DATA_DROP;
          end
        end
        ST_DATA_COPY: if (w_copy_hs && w_rem_last) r_state <= ST_OUTPUT;
        ST_DATA_DROP: if (w_drop_hs && w_rem_last) r_state <= ST_OUTPUT;
        ST_OUTPUT:    if (dst_rdy) r_state <= ST_READY;
        default:      r_state <= ST_READY;
      endcase
    end
  end

  tcp_rx_payload_buf_datapath #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .ADDR_W (ADDR_W)
  ) u_datapath (
    .clk          (clk),
    .rst          (rst),
    .i_load_hdr   (w_hdr_acc),
    .i_load_base  (w_take_slab),
    .i_incr_addr  (w_copy_hs),
    .i_dec_rem    (w_drop_hs),
    .i_set_drop   (w_set_drop),
    .i_len        (src_payload_len),
    .i_base       (alloc_base_addr),
    .o_addr       (w_addr),
    .o_dst_addr   (dst_payload_addr),
    .o_len        (dst_payload_len),
    .o_dropped    (dst_dropped),
    .o_rem_last   (w_rem_last),
    .o_beat_bytes (w_beat_bytes)
  );

  // Beat handshake is passed straight through so a ready buffer sees no bubble.
  assign hdr_src_rdy       = w_hdr_acc;
  assign alloc_consume_val = w_take_slab;
  assign data_src_rdy      = (w_in_copy && store_rdy) || w_in_drop;
  assign store_val         = w_in_copy && src_data_val;
  assign store_data        = src_data;
  assign store_addr        = w_addr;
  assign store_bytes       = w_in_copy ? w_beat_bytes : '0;
  assign store_last        = w_in_copy && w_rem_last;
  assign dst_hdr_val       = (r_state == ST_OUTPUT);

  a_consume_in_ready: assert property (@(posedge clk) disable iff (rst)
    alloc_consume_val |-> r_state == ST_READY);
  a_store_in_copy: assert property (@(posedge clk) disable iff (rst)
    store_val |-> r_state == ST_DATA_COPY);
  a_store_bytes_nonzero: assert property (@(posedge clk) disable iff (rst)
    store_val |-> store_bytes != '0);

endmodule
